// File: rtl/conv_writeback_ctrl_gen.sv
// conv_writeback_ctrl_gen: writeback controller for the conv-kernel PE rows.
// Sequences partial-sum buffer init, conv start and per-row-group drain with
// zero-write over one or more filter passes. Independently muxes NUM_ROWS
// valid-tagged row streams onto NUM_PORTS output ports, one row group at a time.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start_init       start request, honoured only while idle
//   num_passes       passes to run (0 = run until reset), latched on start
//   p_filter_end     filter pass finished, honoured only while waiting for it
//   row_data         NUM_ROWS packed row words, row r at [r*DATA_W +: DATA_W]
//   row_valid        per-row valid
//   p_write_zero     per-row read-out-and-zero strobe
//   p_init           push zeros into empty buffers
//   out_data         NUM_PORTS packed port words, port p at [p*DATA_W +: DATA_W]
//   out_valid        per-port valid
//   start_conv       conv start strobe
//   odd_cnt          ping-pong buffer select
//   busy             controller not idle
//   done             one-cycle pulse after the last pass
//   pat_err          sticky flag for an illegal nonzero row_valid pattern
//   err_cnt          (only with WB_ERR_CNT_EN) saturating count of illegal cycles
//
// Optional feature macro: WB_ERR_CNT_EN adds the err_cnt output.
module conv_writeback_ctrl_gen #(
  parameter int unsigned DATA_W    = 25,
  parameter int unsigned DEPTH     = 61,
  parameter int unsigned NUM_ROWS  = 5,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned PASS_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_init,
  input  logic [PASS_W-1:0]             num_passes,
  input  logic                          p_filter_end,
  input  logic [NUM_ROWS*DATA_W-1:0]    row_data,
  input  logic [NUM_ROWS-1:0]           row_valid,
  output logic [NUM_ROWS-1:0]           p_write_zero,
  output logic                          p_init,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic                          start_conv,
  output logic                          odd_cnt,
  output logic                          busy,
  output logic                          done,
  output logic                          pat_err
`ifdef WB_ERR_CNT_EN
  ,
  output logic [15:0]                   err_cnt
`endif
);

  localparam int unsigned G      = (NUM_ROWS + NUM_PORTS - 1) / NUM_PORTS;
  localparam int unsigned GRP_W  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + START_LEN + 1);
  localparam int unsigned ROW_IW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [3:0] {
    IDLE, INIT_BUFF, START_CONV, WAIT_FILTER, WAIT_ADD,
    WAIT_WRITE, CLEAR_CNT, DRAIN_GRP, CLEAR_GRP, DONE
  } state_t;

  // Row-valid mask of group g: rows g*NUM_PORTS .. min((g+1)*NUM_PORTS, NUM_ROWS)-1.
  function automatic logic [NUM_ROWS-1:0] grp_mask(input int unsigned g);
    logic [NUM_ROWS-1:0] m;
    m = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) m[r] = ((r / NUM_PORTS) == g);
    return m;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GRP_W-1:0]     grp_q, grp_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic [PASS_W-1:0]    npass_q, npass_d;
  logic                 odd_d, p_init_d, start_conv_d, done_d, busy_d;
  logic [NUM_ROWS-1:0]  pwz_d;

  // FSM next state, counters and control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    grp_d        = grp_q;
    pass_d       = pass_q;
    npass_d      = npass_q;
    odd_d        = odd_cnt;
    p_init_d     = 1'b0;
    start_conv_d = 1'b0;
    done_d       = 1'b0;
    pwz_d        = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_init) begin
          state_d = INIT_BUFF;
          npass_d = num_passes;
          pass_d  = '0;
        end
      end
      INIT_BUFF: begin
        p_init_d = 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = START_CONV;
      end
      START_CONV: begin
        start_conv_d = 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1 + START_LEN)) state_d = WAIT_FILTER;
      end
      WAIT_FILTER: begin
        cnt_d = '0;
        if (p_filter_end) state_d = WAIT_ADD;
      end
      WAIT_ADD: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = WAIT_WRITE;
      end
      WAIT_WRITE: state_d = CLEAR_CNT;
      CLEAR_CNT: begin
        cnt_d        = '0;
        start_conv_d = 1'b1;
        odd_d        = ~odd_cnt;
        grp_d        = '0;
        state_d      = DRAIN_GRP;
      end
      DRAIN_GRP: begin
        pwz_d = grp_mask(32'(grp_q));
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          if (grp_q < GRP_W'(G - 1)) begin
            state_d = CLEAR_GRP;
          end else if ((npass_q != '0) && (pass_q == npass_q - PASS_W'(1))) begin
            state_d = DONE;
          end else begin
            // Saturate so free-running mode never wraps the pass count.
            if (pass_q != {PASS_W{1'b1}}) pass_d = pass_q + PASS_W'(1);
            state_d = WAIT_FILTER;
          end
        end
      end
      CLEAR_GRP: begin
        cnt_d   = '0;
        grp_d   = grp_q + GRP_W'(1);
        state_d = DRAIN_GRP;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy tracks the state register itself, so it rises with the first non-idle cycle.
    busy_d = (state_d != IDLE);
  end

  // Row/port output mux, independent of the FSM.
  logic [DATA_W-1:0]           rows [NUM_ROWS];
  logic                        mux_hit;
  int unsigned                 mux_grp;
  int unsigned                 row_sel;
  logic [ROW_IW-1:0]           row_idx;
  logic [NUM_PORTS*DATA_W-1:0] mux_data;
  logic [NUM_PORTS-1:0]        mux_valid;
  logic                        illegal_c;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
    assign rows[r] = row_data[r*DATA_W +: DATA_W];
  end

  always_comb begin
    mux_hit   = 1'b0;
    mux_grp   = 0;
    row_sel   = 0;
    row_idx   = '0;
    mux_data  = '0;
    mux_valid = '0;
    for (int unsigned g = 0; g < G; g++) begin
      if (row_valid == grp_mask(g)) begin
        mux_hit = 1'b1;
        mux_grp = g;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      row_sel = mux_grp * NUM_PORTS + p;
      // Ports beyond the last row of a short group stay zero.
      if (mux_hit && (row_sel < NUM_ROWS)) begin
        row_idx                     = ROW_IW'(row_sel);
        mux_data[p*DATA_W +: DATA_W] = rows[row_idx];
        mux_valid[p]                = row_valid[row_idx];
      end
    end
    illegal_c = (|row_valid) && !mux_hit;
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grp_q        <= '0;
      pass_q       <= '0;
      npass_q      <= '0;
      p_write_zero <= '0;
      p_init       <= 1'b0;
      out_data     <= '0;
      out_valid    <= '0;
      start_conv   <= 1'b0;
      odd_cnt      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pat_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grp_q        <= grp_d;
      pass_q       <= pass_d;
      npass_q      <= npass_d;
      p_write_zero <= pwz_d;
      p_init       <= p_init_d;
      out_data     <= mux_data;
      out_valid    <= mux_valid;
      start_conv   <= start_conv_d;
      odd_cnt      <= odd_d;
      busy         <= busy_d;
      done         <= done_d;
      pat_err      <= pat_err | illegal_c;
    end
  end

`ifdef WB_ERR_CNT_EN
  // Saturating count of cycles with an illegal nonzero valid pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (illegal_c && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
